// File: rtl/stateful_alu_pkg.sv
// Shared opcodes, operand_4 field layout and the combinational helpers used by
// the stateful ALU pipeline stage.
package stateful_alu_pkg;

  // Helpers work on a 64-bit word; callers zero-extend operands and truncate results.
  typedef logic [63:0] word_t;

  localparam logic [7:0] OP_ADD     = 8'h01;
  localparam logic [7:0] OP_SUB     = 8'h02;
  localparam logic [7:0] OP_LOADD   = 8'h07;
  localparam logic [7:0] OP_STORE   = 8'h08;
  localparam logic [7:0] OP_ADD_ALT = 8'h09;
  localparam logic [7:0] OP_SUB_ALT = 8'h0A;
  localparam logic [7:0] OP_LOAD    = 8'h0B;
  localparam logic [7:0] OP_IFELSE  = 8'h0C;
  localparam logic [7:0] OP_SADD    = 8'h0D;
  localparam logic [7:0] OP_SET     = 8'h0E;

  // operand_4: [1:0] rel, [3:2] compare source, [4] then-addend, [5] else-addend, [31:16] cons
  localparam int REL_LSB   = 0;
  localparam int SEL_C_LSB = 2;
  localparam int SEL_T_BIT = 4;
  localparam int SEL_E_BIT = 5;
  localparam int CONS_LSB  = 16;
  localparam int CONS_W    = 16;

  localparam logic [1:0] REL_GT = 2'd0;
  localparam logic [1:0] REL_GE = 2'd1;
  localparam logic [1:0] REL_EQ = 2'd2;
  localparam logic [1:0] REL_NE = 2'd3;

  function automatic word_t mux_two(input word_t a, input word_t b, input logic sel);
    return sel ? b : a;
  endfunction

  function automatic word_t mux_three(input word_t a, input word_t b, input word_t c,
                                      input logic [1:0] sel);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  function automatic logic rel_op(input word_t a, input word_t b, input logic [1:0] rel);
    case (rel)
      REL_GT:  return a > b;
      REL_GE:  return a >= b;
      REL_EQ:  return a == b;
      default: return a != b;
    endcase
  endfunction

  // If (state REL source) then state + addend_t else state - addend_e.
  function automatic word_t stateful_func(input word_t state, input word_t op1,
                                          input word_t op3, input word_t op4);
    word_t cons;
    word_t rhs;
    logic  cond;
    cons = word_t'(op4[CONS_LSB +: CONS_W]);
    rhs  = mux_three(op1, op3, cons, op4[SEL_C_LSB +: 2]);
    cond = rel_op(state, rhs, op4[REL_LSB +: 2]);
    return cond ? state + mux_two(op1, cons, op4[SEL_T_BIT])
                : state - mux_two(op1, cons, op4[SEL_E_BIT]);
  endfunction

  function automatic word_t sat_add(input word_t a, input word_t b, input int width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

  function automatic logic is_stateful(input logic [7:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_LOADD, OP_IFELSE, OP_SADD: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/state_ram_rf.sv
// Simple dual-port state RAM: one synchronous write port and one synchronous
// read-first read port with a read enable.
module state_ram_rf #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: non-blocking writes make a same-cycle read return the old word (read-first).
  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stateful_alu_pipe.sv
// Two-stage stateful ALU: S0 reads the tenant-relative state word, S1 computes,
// commits the write on advance and feeds a valid/ready output register.
module stateful_alu_pipe
  import stateful_alu_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 64,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  output logic                  action_ready,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  input  logic [DATA_WIDTH-1:0] operand_3_in,
  input  logic [DATA_WIDTH-1:0] operand_4_in,
  input  logic [15:0]           page_tbl_out,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  input  logic                  container_out_ready,
  output logic                  overflow_out
);

  localparam int stage_id_unused = STAGE_ID;

  logic [ACTION_LEN-9:0] action_unused;
  assign action_unused = action_in[ACTION_LEN-9:0];

  logic                  accept;
  logic                  advance;
  logic [7:0]            s0_opcode;
  logic [ADDR_W-1:0]     s0_offset;
  logic [ADDR_W-1:0]     s0_addr;

  logic                  s1_valid;
  logic [7:0]            s1_opcode;
  logic [DATA_WIDTH-1:0] s1_op1, s1_op2, s1_op3, s1_op4;
  logic [ADDR_W-1:0]     s1_offset;
  logic [7:0]            s1_len;
  logic [ADDR_W-1:0]     s1_addr;
  logic                  s1_fwd;
  logic [DATA_WIDTH-1:0] s1_fwd_data;

  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] s1_state;
  logic                  s1_overflow;
  logic [DATA_WIDTH-1:0] result;
  logic                  wr_op;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ram_we;
  logic                  fwd_hit;

  assign advance      = !container_out_valid || container_out_ready;
  assign action_ready = !rst_n || !s1_valid || advance;
  assign accept       = action_valid && action_ready;

  assign s0_opcode = action_in[ACTION_LEN-1 -: 8];
  assign s0_offset = operand_2_in[ADDR_W-1:0];
  assign s0_addr   = ADDR_W'(page_tbl_out[7:0]) + s0_offset;

  // Commits are gated by rst_n so an op caught in S1 by reset never writes.
  assign ram_we  = rst_n && s1_valid && advance && wr_op;
  assign fwd_hit = ram_we && (s1_addr == s0_addr);

  state_ram_rf #(
    .DEPTH  (MEM_DEPTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (s1_addr),
    .wdata (wr_data),
    .re    (accept),
    .raddr (s0_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)       s1_valid <= 1'b0;
    else if (accept)  s1_valid <= 1'b1;
    else if (advance) s1_valid <= 1'b0;
  end

  // Payload registers only load on accept; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_opcode   <= s0_opcode;
      s1_op1      <= operand_1_in;
      s1_op2      <= operand_2_in;
      s1_op3      <= operand_3_in;
      s1_op4      <= operand_4_in;
      s1_offset   <= s0_offset;
      s1_len      <= page_tbl_out[15:8];
      s1_addr     <= s0_addr;
      s1_fwd      <= fwd_hit;
      s1_fwd_data <= wr_data;
    end
  end

  assign s1_state    = s1_fwd ? s1_fwd_data : ram_rdata;
  assign s1_overflow = is_stateful(s1_opcode) && (32'(s1_offset) > 32'(s1_len));
  assign wr_data     = (s1_opcode == OP_STORE) ? s1_op1 : result;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    result = s1_op3;
    wr_op  = 1'b0;
    case (s1_opcode)
      OP_LOAD:   result = s1_state;
      OP_STORE:  wr_op  = 1'b1;
      OP_LOADD: begin
        result = s1_state + DATA_WIDTH'(1);
        wr_op  = 1'b1;
      end
      OP_IFELSE: begin
        result = DATA_WIDTH'(stateful_func(word_t'(s1_state), word_t'(s1_op1),
                                           word_t'(s1_op3), word_t'(s1_op4)));
        wr_op  = 1'b1;
      end
      OP_SADD: begin
        result = DATA_WIDTH'(sat_add(word_t'(s1_state), word_t'(s1_op1), DATA_WIDTH));
        wr_op  = 1'b1;
      end
      OP_ADD, OP_ADD_ALT: result = s1_op1 + s1_op2;
      OP_SUB, OP_SUB_ALT: result = s1_op1 - s1_op2;
      OP_SET:             result = s1_op2;
      default:            result = s1_op3;
    endcase
    if (s1_overflow) begin
      result = s1_op3;
      wr_op  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      container_out_valid <= 1'b0;
      container_out       <= '0;
      overflow_out        <= 1'b0;
    end else if (advance) begin
      container_out_valid <= s1_valid;
      if (s1_valid) begin
        container_out <= result;
        overflow_out  <= s1_overflow;
      end
    end
  end

endmodule

// File: tb/tb_stateful_alu_pipe.sv
// Self-checking bench: directed vector table, hand-written stall/reset sequences
// and randomized traffic scored against a behavioural state-RAM model.
module tb_stateful_alu_pipe;

  localparam int DW    = 32;
  localparam int AL    = 64;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AL-1:0] action_in;
  logic          action_valid;
  logic          action_ready;
  logic [DW-1:0] operand_1_in, operand_2_in, operand_3_in, operand_4_in;
  logic [15:0]   page_tbl_out;
  logic [DW-1:0] container_out;
  logic          container_out_valid;
  logic          container_out_ready;
  logic          overflow_out;

  always #5 clk = ~clk;

  stateful_alu_pipe dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .action_in           (action_in),
    .action_valid        (action_valid),
    .action_ready        (action_ready),
    .operand_1_in        (operand_1_in),
    .operand_2_in        (operand_2_in),
    .operand_3_in        (operand_3_in),
    .operand_4_in        (operand_4_in),
    .page_tbl_out        (page_tbl_out),
    .container_out       (container_out),
    .container_out_valid (container_out_valid),
    .container_out_ready (container_out_ready),
    .overflow_out        (overflow_out)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] op1, op2, op3, op4;
    logic [7:0]  base, len;
  } act_t;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    int          id;
  } exp_t;

  typedef struct {
    act_t        a;
    logic [31:0] out;
    logic        ovf;
  } vec_t;

  logic [31:0] mem_model [DEPTH];
  exp_t        exp_q [$];
  vec_t        tbl [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          next_id  = 0;
  int          last_tries;
  logic        model_en     = 1'b0;
  logic        use_override = 1'b0;
  exp_t        override_exp;
  logic        last_accept;
  logic        hold_pending = 1'b0;
  logic [31:0] held_out;
  logic        held_ovf;
  act_t        idle = '{default: '0};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic act_t mk(input logic [7:0] op, input logic [7:0] base, input logic [7:0] len,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] op3, input logic [31:0] op4);
    act_t a;
    a.op = op; a.base = base; a.len = len;
    a.op1 = op1; a.op2 = op2; a.op3 = op3; a.op4 = op4;
    return a;
  endfunction

  // Reference semantics applied in program order at accept time.
  function automatic void model_exec(input act_t a, output logic [31:0] out, output logic ovf);
    int          off, phys, selc;
    logic [63:0] s, r, rhs, cons, addend;
    logic        cond;
    off  = int'(a.op2[4:0]);
    phys = (int'(a.base) + off) % DEPTH;
    s    = 64'(mem_model[phys]);
    ovf  = (a.op inside {8'h0B, 8'h08, 8'h07, 8'h0C, 8'h0D}) && (off > int'(a.len));
    out  = a.op3;
    if (ovf) return;
    case (a.op)
      8'h0B: out = mem_model[phys];
      8'h08: mem_model[phys] = a.op1;
      8'h07: begin
        r = s + 64'd1;
        out = r[31:0];
        mem_model[phys] = out;
      end
      8'h0C: begin
        cons = 64'(a.op4 >> 16);
        selc = int'((a.op4 >> 2) & 32'd3);
        rhs  = (selc == 0) ? 64'(a.op1) : (selc == 1) ? 64'(a.op3) : cons;
        case (a.op4 & 32'd3)
          32'd0:   cond = s > rhs;
          32'd1:   cond = s >= rhs;
          32'd2:   cond = s == rhs;
          default: cond = s != rhs;
        endcase
        if (cond) begin
          addend = a.op4[4] ? cons : 64'(a.op1);
          r = s + addend;
        end else begin
          addend = a.op4[5] ? cons : 64'(a.op1);
          r = s - addend;
        end
        out = r[31:0];
        mem_model[phys] = out;
      end
      8'h0D: begin
        r = s + 64'(a.op1);
        out = (r > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : r[31:0];
        mem_model[phys] = out;
      end
      8'h01, 8'h09: out = a.op1 + a.op2;
      8'h02, 8'h0A: out = a.op1 - a.op2;
      8'h0E:        out = a.op2;
      default:      out = a.op3;
    endcase
  endfunction

  // One clock: drive at negedge, sample 1 ns later, score output and accept.
  task automatic cycle(input logic v, input act_t a, input logic ordy, input logic rstn);
    exp_t        e;
    logic [31:0] mo;
    logic        mv;
    @(negedge clk);
    rst_n               = rstn;
    action_valid        = v;
    action_in           = {a.op, 56'h0};
    operand_1_in        = a.op1;
    operand_2_in        = a.op2;
    operand_3_in        = a.op3;
    operand_4_in        = a.op4;
    page_tbl_out        = {a.len, a.base};
    container_out_ready = ordy;
    #1;
    if (hold_pending) begin
      check("hold_valid", 32'(container_out_valid), 32'd1);
      check("hold_data", container_out, held_out);
      check("hold_ovf", 32'(overflow_out), 32'(held_ovf));
    end
    hold_pending = rstn && container_out_valid && !container_out_ready;
    held_out     = container_out;
    held_ovf     = overflow_out;
    if (model_en && container_out_valid && container_out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no output", container_out);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("out[%0d]", e.id), container_out, e.out);
        check($sformatf("ovf[%0d]", e.id), 32'(overflow_out), 32'(e.ovf));
      end
    end
    last_accept = v && action_ready && rstn;
    if (model_en && last_accept) begin
      model_exec(a, mo, mv);
      if (use_override) e = override_exp;
      else begin
        e.out = mo;
        e.ovf = mv;
      end
      e.id = next_id++;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input act_t a, input logic ordy);
    last_tries = 0;
    do begin
      cycle(1'b1, a, ordy, 1'b1);
      last_tries++;
    end while (!last_accept && last_tries < 50);
    if (!last_accept) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got no accept in %0d cycles, expected accept", last_tries);
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cycle(1'b0, idle, 1'b1, 1'b1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] ops [11] = '{8'h0B, 8'h08, 8'h07, 8'h0C, 8'h0D, 8'h01, 8'h09, 8'h02, 8'h0A, 8'h0E, 8'h3C};
    int   accepted;
    act_t ra;

    rst_n = 1'b0; action_valid = 1'b0; action_in = '0; container_out_ready = 1'b1;
    operand_1_in = '0; operand_2_in = '0; operand_3_in = '0; operand_4_in = '0; page_tbl_out = '0;

    // Reset state
    repeat (3) cycle(1'b0, idle, 1'b1, 1'b0);
    check("rst_valid", 32'(container_out_valid), 32'd0);
    check("rst_out", container_out, 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_ready", 32'(action_ready), 32'd1);
    cycle(1'b0, idle, 1'b1, 1'b1);
    check("rst_ready_after", 32'(action_ready), 32'd1);

    // Known RAM contents: every entry zeroed
    model_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) issue(mk(8'h08, 8'd0, 8'd31, 32'd0, i, i, 32'd0), 1'b1);
    drain(20);

    // Latency: accept at t, valid at t+2
    issue(mk(8'h0B, 8'd0, 8'd31, 32'd0, 32'd2, 32'd0, 32'd0), 1'b1);
    cycle(1'b0, idle, 1'b1, 1'b1);
    check("lat_t1_valid", 32'(container_out_valid), 32'd0);
    cycle(1'b0, idle, 1'b1, 1'b1);
    check("lat_t2_valid", 32'(container_out_valid), 32'd1);
    drain(10);

    // Directed vectors with hand-computed expectations
    tbl.push_back('{mk(8'h08, 8'd4,   8'd31, 32'h55, 32'd3,  32'hAAAA, 0), 32'hAAAA, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd4,   8'd31, 32'h0,  32'd3,  32'h0, 0),    32'h55, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd31, 32'h0,  32'd7,  32'h0, 0),    32'h55, 1'b0});
    tbl.push_back('{mk(8'h07, 8'd0,   8'd31, 32'h0,  32'd0,  32'h0, 0),    32'd1, 1'b0});
    tbl.push_back('{mk(8'h07, 8'd0,   8'd31, 32'h0,  32'd0,  32'h0, 0),    32'd2, 1'b0});
    tbl.push_back('{mk(8'h07, 8'd0,   8'd31, 32'h0,  32'd0,  32'h0, 0),    32'd3, 1'b0});
    tbl.push_back('{mk(8'h07, 8'd0,   8'd31, 32'h0,  32'd0,  32'h0, 0),    32'd4, 1'b0});
    tbl.push_back('{mk(8'h08, 8'd0,   8'd31, 32'h20, 32'd10, 32'h0, 0),    32'h0, 1'b0});
    tbl.push_back('{mk(8'h0D, 8'd0,   8'd31, 32'hFFFFFFF0, 32'd10, 32'h0, 0), 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd31, 32'h0,  32'd10, 32'h0, 0),    32'hFFFFFFFF, 1'b0});
    tbl.push_back('{mk(8'h08, 8'd0,   8'd8,  32'h77, 32'd9,  32'h1234, 0), 32'h1234, 1'b1});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd31, 32'h0,  32'd9,  32'h0, 0),    32'h0, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd8,  32'h0,  32'd8,  32'h0, 0),    32'h0, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd8,  32'h0,  32'd9,  32'h99, 0),   32'h99, 1'b1});
    tbl.push_back('{mk(8'h01, 8'd0,   8'd0,  32'd5,  32'd3,  32'h0, 0),    32'd8, 1'b0});
    tbl.push_back('{mk(8'h0A, 8'd0,   8'd0,  32'd3,  32'd5,  32'h0, 0),    32'hFFFFFFFE, 1'b0});
    tbl.push_back('{mk(8'h0E, 8'd0,   8'd0,  32'h0,  32'hABCDEF01, 32'h0, 0), 32'hABCDEF01, 1'b0});
    tbl.push_back('{mk(8'h3F, 8'd0,   8'd0,  32'h0,  32'd0,  32'hDEAD, 0), 32'hDEAD, 1'b0});
    tbl.push_back('{mk(8'h0C, 8'd0,   8'd31, 32'h0,  32'd7,  32'h0, 32'h0050_0018), 32'hA5, 1'b0});
    tbl.push_back('{mk(8'h0C, 8'd0,   8'd31, 32'h10, 32'd7,  32'h0, 32'h0000_0002), 32'h95, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd31, 32'h0,  32'd7,  32'h0, 0),    32'h95, 1'b0});
    tbl.push_back('{mk(8'h07, 8'hF0, 8'd31, 32'h0,  32'd26, 32'h0, 0),    32'h0, 1'b0});
    tbl.push_back('{mk(8'h0B, 8'd0,   8'd31, 32'h0,  32'd10, 32'h0, 0),    32'h0, 1'b0});
    use_override = 1'b1;
    foreach (tbl[i]) begin
      override_exp.out = tbl[i].out;
      override_exp.ovf = tbl[i].ovf;
      issue(tbl[i].a, 1'b1);
      check($sformatf("tput[%0d]", i), 32'(last_tries), 32'd1);
    end
    use_override = 1'b0;
    drain(10);

    // Back-pressure during a loadd stream at offset 5
    issue(mk(8'h08, 8'd0, 8'd31, 32'd0, 32'd5, 32'd0, 32'd0), 1'b1);
    drain(10);
    ra = mk(8'h07, 8'd0, 8'd31, 32'd0, 32'd5, 32'd0, 32'd0);
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, ra, 1'b0, 1'b1);
      check($sformatf("stall_ready[%0d]", k), 32'(action_ready), 32'(k < 2));
      if (last_accept) accepted++;
    end
    for (int k = 0; k < 20 && accepted < 4; k++) begin
      cycle(1'b1, ra, 1'b1, 1'b1);
      if (last_accept) accepted++;
    end
    check("stall_accepts", 32'(accepted), 32'd4);
    drain(10);
    issue(mk(8'h0B, 8'd0, 8'd31, 32'd0, 32'd5, 32'd0, 32'd0), 1'b1);
    drain(10);

    // Reset mid-stream: only the loadd that committed before reset may land
    model_en = 1'b0;
    ra = mk(8'h07, 8'd0, 8'd31, 32'd0, 32'd20, 32'd0, 32'd0);
    cycle(1'b1, ra, 1'b1, 1'b1);
    cycle(1'b1, ra, 1'b1, 1'b1);
    cycle(1'b1, ra, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0);
    check("mid_rst_valid", 32'(container_out_valid), 32'd0);
    check("mid_rst_out", container_out, 32'd0);
    check("mid_rst_ovf", 32'(overflow_out), 32'd0);
    check("mid_rst_ready", 32'(action_ready), 32'd1);
    cycle(1'b0, idle, 1'b1, 1'b1);
    check("mid_rst_ready_after", 32'(action_ready), 32'd1);
    check("mid_rst_valid_after", 32'(container_out_valid), 32'd0);
    model_en = 1'b1;
    mem_model[20] = mem_model[20] + 32'd1;
    issue(mk(8'h0B, 8'd0, 8'd31, 32'd0, 32'd20, 32'd0, 32'd0), 1'b1);
    drain(10);

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 600; n++) begin
      ra.op   = ops[$urandom_range(0, 10)];
      ra.op1  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      ra.op2  = $urandom;
      ra.op3  = $urandom;
      ra.op4  = $urandom;
      ra.base = 8'($urandom);
      ra.len  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : 8'd31;
      cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0, 1'b1);
    end
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
